gpio_irq: RTL and testbench

Parametrised general-purpose I/O peripheral on the CPU data bus, replacing the fixed 16-bit GPIO. It provides WIDTH bidirectional pins with per-pin direction, atomic set/clear/toggle of outputs, multi-stage input synchronisation, and per-pin rising/falling edge interrupts with sticky write-1-to-clear status. It aggregates the interrupts into one level-sensitive `irq` line for the interrupt controller.

---
 rtl/gpio_irq_pkg.sv | 30 +++
 rtl/gpio_irq_sync_chain.sv | 30 +++
 rtl/gpio_irq.sv | 130 +++++++++++++
 tb/tb_gpio_irq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the GPIO peripheral: register indices, the address
// field position and the byte-lane mask helper.
package gpio_irq_pkg;

    localparam int unsigned GPIO_ADDR_LSB = 2;
    localparam int unsigned GPIO_ADDR_W   = 4;

    typedef enum logic [3:0] {
        GPIO_REG_DATA_IN    = 4'd0,
        GPIO_REG_DATA_OUT   = 4'd1,
        GPIO_REG_DIR        = 4'd2,
        GPIO_REG_OUT_SET    = 4'd3,
        GPIO_REG_OUT_CLR    = 4'd4,
        GPIO_REG_OUT_TGL    = 4'd5,
        GPIO_REG_IRQ_EN     = 4'd6,
        GPIO_REG_IRQ_RISE   = 4'd7,
        GPIO_REG_IRQ_FALL   = 4'd8,
        GPIO_REG_IRQ_STATUS = 4'd9
    } gpio_reg_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        logic [31:0] m;
        m = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            m[8*n +: 8] = {8{we[n]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_irq_sync_chain.sv
// Reset-to-0 multi-flop synchroniser for asynchronous inputs; reusable by
// any peripheral that samples pads.
module sync_chain #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// Parametrised GPIO with per-pin direction, atomic set/clear/toggle and
// edge interrupts with sticky W1C status aggregated onto one irq line.
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gpio_ce,
    input  logic [3:0]       bus_we,
    input  logic             bus_re,
    input  logic [31:0]      bus_wdata,
    input  logic [16:0]      bus_addr,
    output logic [31:0]      bus_rdata,
    output logic             irq,
    inout  logic [WIDTH-1:0] gpio_io
);

    localparam int unsigned WARM = SYNC_STAGES + 1;
    localparam int unsigned CW   = $clog2(WARM + 1);

    logic [WIDTH-1:0] dout_q, dout_d, dir_q, dir_d;
    logic [WIDTH-1:0] ien_q, ien_d, rise_q, rise_d, fall_q, fall_d;
    logic [WIDTH-1:0] stat_q, stat_d, prev_q;
    logic [WIDTH-1:0] sync_w, event_w, lane_m, wbits;
    logic [CW-1:0]    warm_q, warm_d;
    logic [31:0]      rdata_q, rdata_d, rd_word, lane_full, wdata_full;
    gpio_reg_e        reg_sel;
    logic             wr_en, rd_en, warm_done;
    logic             unused_bits;

    assign reg_sel    = gpio_reg_e'(bus_addr[GPIO_ADDR_LSB +: GPIO_ADDR_W]);
    assign wr_en      = gpio_ce && (|bus_we);
    assign rd_en      = gpio_ce && bus_re;
    assign lane_full  = lane_mask(bus_we);
    assign wdata_full = lane_full & bus_wdata;
    assign lane_m     = lane_full[WIDTH-1:0];
    assign wbits      = wdata_full[WIDTH-1:0];
    assign unused_bits = ^{bus_addr, lane_full, wdata_full};

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (gpio_io),
        .q_o    (sync_w)
    );

    // Edges are ignored until sync and prev have both filled from the pads.
    assign warm_done = (warm_q == CW'(WARM));
    assign event_w   = warm_done ? ((sync_w & ~prev_q & rise_q) |
                                    (~sync_w & prev_q & fall_q)) : '0;

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            GPIO_REG_DATA_IN:    rd_word[WIDTH-1:0] = sync_w;
            GPIO_REG_DATA_OUT:   rd_word[WIDTH-1:0] = dout_q;
            GPIO_REG_DIR:        rd_word[WIDTH-1:0] = dir_q;
            GPIO_REG_IRQ_EN:     rd_word[WIDTH-1:0] = ien_q;
            GPIO_REG_IRQ_RISE:   rd_word[WIDTH-1:0] = rise_q;
            GPIO_REG_IRQ_FALL:   rd_word[WIDTH-1:0] = fall_q;
            GPIO_REG_IRQ_STATUS: rd_word[WIDTH-1:0] = stat_q;
            default:             rd_word = '0;
        endcase
        rdata_d = rd_en ? rd_word : rdata_q;
    end

    always_comb begin
        dout_d = dout_q;
        dir_d  = dir_q;
        ien_d  = ien_q;
        rise_d = rise_q;
        fall_d = fall_q;
        stat_d = stat_q;
        if (wr_en) begin
            case (reg_sel)
                GPIO_REG_DATA_OUT:   dout_d = (dout_q & ~lane_m) | wbits;
                GPIO_REG_DIR:        dir_d  = (dir_q  & ~lane_m) | wbits;
                GPIO_REG_OUT_SET:    dout_d = dout_q | wbits;
                GPIO_REG_OUT_CLR:    dout_d = dout_q & ~wbits;
                GPIO_REG_OUT_TGL:    dout_d = dout_q ^ wbits;
                GPIO_REG_IRQ_EN:     ien_d  = (ien_q  & ~lane_m) | wbits;
                GPIO_REG_IRQ_RISE:   rise_d = (rise_q & ~lane_m) | wbits;
                GPIO_REG_IRQ_FALL:   fall_d = (fall_q & ~lane_m) | wbits;
                GPIO_REG_IRQ_STATUS: stat_d = stat_q & ~wbits;
                default:             ;
            endcase
        end
        // New events are OR-ed after the W1C so a coincident set wins.
        stat_d = stat_d | event_w;
        warm_d = warm_done ? warm_q : warm_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            dir_q   <= '0;
            ien_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            stat_q  <= '0;
            prev_q  <= '0;
            warm_q  <= '0;
            rdata_q <= '0;
        end else begin
            dout_q  <= dout_d;
            dir_q   <= dir_d;
            ien_q   <= ien_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            stat_q  <= stat_d;
            prev_q  <= sync_w;
            warm_q  <= warm_d;
            rdata_q <= rdata_d;
        end
    end

    assign irq       = |(stat_q & ien_q);
    assign bus_rdata = rd_en ? rdata_q : 'z;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio_io[i] = dir_q[i] ? dout_q[i] : 1'bz;
    end

endmodule

// File: tb/tb_gpio_irq.sv
// Directed self-checking bench for gpio_irq (WIDTH=16, SYNC_STAGES=2).
module tb_gpio_irq;

    localparam logic [3:0] R_DIN  = 4'd0;
    localparam logic [3:0] R_DOUT = 4'd1;
    localparam logic [3:0] R_DIR  = 4'd2;
    localparam logic [3:0] R_SET  = 4'd3;
    localparam logic [3:0] R_CLR  = 4'd4;
    localparam logic [3:0] R_TGL  = 4'd5;
    localparam logic [3:0] R_EN   = 4'd6;
    localparam logic [3:0] R_RISE = 4'd7;
    localparam logic [3:0] R_FALL = 4'd8;
    localparam logic [3:0] R_STAT = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        gpio_ce = 1'b0;
    logic [3:0]  bus_we = 4'h0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [16:0] bus_addr = '0;
    wire  [31:0] bus_rdata;
    wire         irq;
    wire  [15:0] pad;
    logic [15:0] tb_en = 16'hFFFF;
    logic [15:0] tb_val = 16'hFFFF;
    logic [31:0] rv;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 16; i++) begin : g_drv
        assign pad[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    gpio_irq #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gpio_ce   (gpio_ce),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_wdata (bus_wdata),
        .bus_addr  (bus_addr),
        .bus_rdata (bus_rdata),
        .irq       (irq),
        .gpio_io   (pad)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] idx, input logic [3:0] we, input logic [31:0] data);
        @(negedge clk);
        gpio_ce = 1'b1; bus_we = we; bus_addr = {11'b0, idx, 2'b00}; bus_wdata = data;
        @(posedge clk); #1;
        gpio_ce = 1'b0; bus_we = 4'h0;
    endtask

    task automatic rd(input logic [3:0] idx, output logic [31:0] data);
        @(negedge clk);
        gpio_ce = 1'b1; bus_re = 1'b1; bus_addr = {11'b0, idx, 2'b00};
        @(posedge clk); #1;
        data = bus_rdata;
        gpio_ce = 1'b0; bus_re = 1'b0;
    endtask

    task automatic release_with_rise();
        @(negedge clk);
        rst_n = 1'b1;
        gpio_ce = 1'b1; bus_we = 4'hF; bus_addr = {11'b0, R_RISE, 2'b00}; bus_wdata = 32'h0000_FFFF;
        @(posedge clk); #1;
        gpio_ce = 1'b0; bus_we = 4'h0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", irq, 0);
        chk("rst_pad_high", pad, 16'hFFFF);
        tb_val = 16'h0000;
        #1 chk("rst_pad_z", pad, 16'h0000);
        tb_val = 16'hFFFF;

        // Pads high through reset; RISE armed on the first edge after release.
        release_with_rise();
        rd(R_DIN, rv);  chk("din_early", rv, 32'h0000_0000);
        rd(R_DIN, rv);  chk("din_synced", rv, 32'h0000_FFFF);
        rd(R_STAT, rv); chk("warmup_stat", rv, 32'h0000_0000);
        chk("warmup_irq", irq, 0);

        // Outputs and atomic set/clear/toggle.
        wr(R_RISE, 4'hF, 32'h0);
        tb_en = 16'hFF00; tb_val = 16'h5A00;
        wr(R_DIR,  4'hF, 32'h0000_00FF);
        wr(R_DOUT, 4'hF, 32'h0000_00A5);
        wr(R_SET,  4'hF, 32'h0000_0002);
        wr(R_CLR,  4'hF, 32'h0000_0001);
        wr(R_TGL,  4'hF, 32'h0000_0080);
        chk("pad_out", pad, 16'h5A26);
        rd(R_DOUT, rv); chk("dout_rd", rv, 32'h0000_0026);
        rd(R_DIR, rv);  chk("dir_rd", rv, 32'h0000_00FF);
        rd(R_DIN, rv);  chk("din_driven", rv, 32'h0000_5A26);

        // Byte-lane gating.
        wr(R_DIR, 4'hF, 32'h0);
        tb_en = 16'h00FF; tb_val = 16'h0000;
        wr(R_DIR, 4'b0010, 32'hFFFF_FFFF);
        rd(R_DIR, rv);  chk("dir_lane1", rv, 32'h0000_FF00);
        wr(R_DOUT, 4'b0010, 32'h0000_3C00);
        wr(R_CLR, 4'b0001, 32'hFFFF_FFFF);
        rd(R_DOUT, rv); chk("dout_lanes", rv, 32'h0000_3C00);
        chk("pad_hi_byte", pad, 16'h3C00);
        rd(R_SET, rv);  chk("wo_reads0", rv, 32'h0);
        rd(4'd12, rv);  chk("idx12_reads0", rv, 32'h0);
        rd(R_DIN, rv);  chk("din_hi_byte", rv, 32'h0000_3C00);

        // Rising-edge interrupt latency and W1C.
        wr(R_DIR, 4'hF, 32'h0);
        tb_en = 16'hFFFF; tb_val = 16'h0000;
        repeat (4) @(posedge clk);
        wr(R_STAT, 4'hF, 32'h0000_FFFF);
        wr(R_RISE, 4'hF, 32'h0000_0010);
        wr(R_EN,   4'hF, 32'h0000_0010);
        @(negedge clk); tb_val[4] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 chk("rise_irq_e2", irq, 0);
        @(posedge clk); #1 chk("rise_irq_e3", irq, 1);
        rd(R_STAT, rv); chk("rise_stat", rv, 32'h0000_0010);
        wr(R_STAT, 4'hF, 32'h0000_0010);
        chk("w1c_irq", irq, 0);

        // Falling event coincident with W1C: set wins.
        wr(R_FALL, 4'hF, 32'h0000_0008);
        wr(R_EN,   4'hF, 32'h0000_0018);
        @(negedge clk); tb_val[3] = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("no_rise3", irq, 0);
        @(negedge clk); tb_val[3] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1 chk("fall_irq", irq, 1);
        @(negedge clk); tb_val[3] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); tb_val[3] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        gpio_ce = 1'b1; bus_we = 4'hF; bus_addr = {11'b0, R_STAT, 2'b00}; bus_wdata = 32'h0000_0008;
        @(posedge clk); #1;
        gpio_ce = 1'b0; bus_we = 4'h0;
        chk("setwins_irq", irq, 1);
        rd(R_STAT, rv); chk("setwins_stat", rv, 32'h0000_0008);
        wr(R_STAT, 4'hF, 32'h0000_0008);
        chk("w1c3_irq", irq, 0);

        // Enable gating, then asynchronous reset mid-cycle.
        wr(R_FALL, 4'hF, 32'h0);
        wr(R_RISE, 4'hF, 32'h0000_0011);
        wr(R_EN,   4'hF, 32'h0000_0011);
        @(negedge clk); tb_val[4] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); tb_val[0] = 1'b1; tb_val[4] = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("two_irq", irq, 1);
        rd(R_STAT, rv); chk("two_stat", rv, 32'h0000_0011);
        wr(R_EN, 4'hF, 32'h0);
        chk("en_off_irq", irq, 0);
        rd(R_STAT, rv); chk("en_off_stat", rv, 32'h0000_0011);
        wr(R_EN, 4'hF, 32'h0000_0011);
        chk("en_on_irq", irq, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 chk("async_rst_irq", irq, 0);
        repeat (2) @(posedge clk);
        release_with_rise();
        wr(R_EN, 4'hF, 32'h0000_FFFF);
        repeat (4) @(posedge clk);
        #1 chk("rewarm_irq", irq, 0);
        rd(R_STAT, rv); chk("rewarm_stat", rv, 32'h0);
        rd(R_DIN, rv);  chk("rewarm_din", rv, 32'h0000_0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
